sccb_master: RTL and testbench



---
 rtl/sccb_master.sv | 228 ++++++++++++++++++++++
 tb/tb_sccb_master.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// SCCB / I2C-style configuration master: register writes and two-phase register reads
// over open-drain SIOC/SIOD, with optional ACK checking and NACK abort.
module sccb_master #(
    parameter int         CLK_FREQ   = 25000000,
    parameter int         SCCB_FREQ  = 100000,
    parameter logic [6:0] DEV_ADDR   = 7'h21,
    parameter int         ADDR_BYTES = 1,
    parameter bit         CHECK_ACK  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    rw,
    input  logic [8*ADDR_BYTES-1:0] reg_addr,
    input  logic [7:0]              wdata,
    input  logic                    SIOD_in,
    output logic                    ready,
    output logic                    done,
    output logic                    nack,
    output logic [7:0]              rdata,
    output logic                    SIOC_oe,
    output logic                    SIOD_oe
);
    localparam int            Q      = CLK_FREQ / (4 * SCCB_FREQ);
    localparam int            TW     = $clog2(Q);
    localparam logic [TW-1:0] Q_M1   = TW'(Q - 1);
    localparam int            AW     = 8 * ADDR_BYTES;
    localparam logic [1:0]    LAST_R = 2'(ADDR_BYTES);
    localparam logic [1:0]    LAST_W = 2'(ADDR_BYTES + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_BIT_LOW, ST_BIT_DRIVE, ST_BIT_HIGH,
        ST_STOP_1, ST_STOP_2, ST_STOP_3, ST_STOP_4, ST_GAP
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          high2_q, high2_d;
    logic [3:0]    bit_q, bit_d;
    logic [1:0]    byte_q, byte_d;
    logic [2:0]    gap_q, gap_d;
    logic          phase2_q, phase2_d;
    logic          abort_q, abort_d;
    logic          rw_q, rw_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic [7:0]    rx_q, rx_d;
    logic [7:0]    rdata_q, rdata_d;
    logic          nack_q, nack_d;
    logic          done_q, done_d;
    logic          sioc_q, sioc_d;
    logic          siod_q, siod_d;

    logic [7:0] tx_byte;
    logic       rd_byte, last_byte, tx_bit;

    // Address bytes are consumed from the top of addr_q, which shifts after each one.
    always_comb begin
        tx_byte = wdata_q;
        if (phase2_q)                tx_byte = {DEV_ADDR, 1'b1};
        else if (byte_q == 2'd0)     tx_byte = {DEV_ADDR, 1'b0};
        else if (byte_q <= LAST_R)   tx_byte = addr_q[AW-1 -: 8];
    end

    assign rd_byte   = phase2_q && (byte_q == 2'd1);
    assign last_byte = phase2_q ? (byte_q == 2'd1) : (byte_q == (rw_q ? LAST_R : LAST_W));
    assign tx_bit    = tx_byte[3'd7 - bit_q[2:0]];

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        high2_d  = high2_q;
        bit_d    = bit_q;
        byte_d   = byte_q;
        gap_d    = gap_q;
        phase2_d = phase2_q;
        abort_d  = abort_q;
        rw_d     = rw_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rx_d     = rx_q;
        rdata_d  = rdata_q;
        nack_d   = nack_q;
        sioc_d   = sioc_q;
        siod_d   = siod_q;
        done_d   = 1'b0;
        if (state_q == ST_IDLE) begin
            if (start) begin
                state_d  = ST_START;
                timer_d  = Q_M1;
                rw_d     = rw;
                addr_d   = reg_addr;
                wdata_d  = wdata;
                phase2_d = 1'b0;
                byte_d   = 2'd0;
                bit_d    = 4'd0;
                abort_d  = 1'b0;
                nack_d   = 1'b0;
                siod_d   = 1'b1;
            end
        end else if (timer_q != '0) begin
            timer_d = timer_q - 1'b1;
        end else begin
            timer_d = Q_M1;
            case (state_q)
                ST_START: begin
                    state_d = ST_BIT_LOW;
                    sioc_d  = 1'b1;
                end
                ST_BIT_LOW: begin
                    state_d = ST_BIT_DRIVE;
                    siod_d  = (bit_q != 4'd8) && !rd_byte && !tx_bit;
                end
                ST_BIT_DRIVE: begin
                    state_d = ST_BIT_HIGH;
                    high2_d = 1'b0;
                    sioc_d  = 1'b0;
                end
                ST_BIT_HIGH: begin
                    if (!high2_q) begin
                        high2_d = 1'b1;
                        if (bit_q == 4'd8) begin
                            if (CHECK_ACK && !rd_byte && SIOD_in) abort_d = 1'b1;
                        end else if (rd_byte) begin
                            rx_d = {rx_q[6:0], SIOD_in};
                        end
                    end else begin
                        sioc_d = 1'b1;
                        if (bit_q != 4'd8) begin
                            state_d = ST_BIT_LOW;
                            bit_d   = bit_q + 4'd1;
                        end else if (abort_q || last_byte) begin
                            state_d = ST_STOP_1;
                        end else begin
                            state_d = ST_BIT_LOW;
                            bit_d   = 4'd0;
                            byte_d  = byte_q + 2'd1;
                            if (!phase2_q && byte_q != 2'd0) addr_d = addr_q << 8;
                        end
                    end
                end
                ST_STOP_1: begin
                    state_d = ST_STOP_2;
                    siod_d  = 1'b1;
                end
                ST_STOP_2: begin
                    state_d = ST_STOP_3;
                    sioc_d  = 1'b0;
                end
                ST_STOP_3: begin
                    state_d = ST_STOP_4;
                    siod_d  = 1'b0;
                end
                ST_STOP_4: begin
                    // A read repeats the frame with the read device byte after its address phase.
                    if (rw_q && !phase2_q && !abort_q) begin
                        state_d  = ST_START;
                        phase2_d = 1'b1;
                        byte_d   = 2'd0;
                        bit_d    = 4'd0;
                        siod_d   = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                        gap_d   = 3'd0;
                    end
                end
                ST_GAP: begin
                    if (gap_q == 3'd7) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        nack_d  = abort_q;
                        if (rw_q && !abort_q) rdata_d = rx_q;
                    end else begin
                        gap_d = gap_q + 3'd1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            high2_q  <= 1'b0;
            bit_q    <= 4'd0;
            byte_q   <= 2'd0;
            gap_q    <= 3'd0;
            phase2_q <= 1'b0;
            abort_q  <= 1'b0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 8'h00;
            rx_q     <= 8'h00;
            rdata_q  <= 8'h00;
            nack_q   <= 1'b0;
            done_q   <= 1'b0;
            sioc_q   <= 1'b0;
            siod_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            high2_q  <= high2_d;
            bit_q    <= bit_d;
            byte_q   <= byte_d;
            gap_q    <= gap_d;
            phase2_q <= phase2_d;
            abort_q  <= abort_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rx_q     <= rx_d;
            rdata_q  <= rdata_d;
            nack_q   <= nack_d;
            done_q   <= done_d;
            sioc_q   <= sioc_d;
            siod_q   <= siod_d;
        end
    end

    assign ready   = (state_q == ST_IDLE);
    assign done    = done_q;
    assign nack    = nack_q;
    assign rdata   = rdata_q;
    assign SIOC_oe = sioc_q;
    assign SIOD_oe = siod_q;
endmodule

// File: tb/tb_sccb_master.sv
// Scoreboard bench for sccb_master: bus tokens and done records are queued at issue
// and checked by per-instance bus decoders and done monitors.
module tb_sccb_master;
    localparam int Q = 10;
    localparam logic [9:0] T_START = 10'h200;
    localparam logic [9:0] T_STOP  = 10'h201;

    typedef struct { int inst; logic [9:0] tok; } tok_t;
    typedef struct { int inst; int t0; int cyc; logic nack; logic [7:0] rdata; } done_t;

    tok_t  tq[$];
    done_t dq[$];
    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  start_v = 2'b00;
    logic        rw = 1'b0;
    logic [15:0] reg_addr = 16'h0000;
    logic [7:0]  wdata = 8'h00;
    logic        ack_en = 1'b1;
    logic [7:0]  slave_data = 8'h00;

    wire [1:0]  ready_v, done_v, nack_v, sioc_v, siod_v, sda_v;
    wire [15:0] rdata_v;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic emit(input int inst, input logic [9:0] tok);
        tok_t e;
        total++;
        if (tq.size() == 0) begin
            $display("FAIL bus_token[%0d]: got %h, none expected", inst, tok);
        end else begin
            e = tq.pop_front();
            if (e.inst == inst && e.tok == tok) passed++;
            else $display("FAIL bus_token[%0d]: got %h, expected %h from dut %0d", inst, tok, e.tok, e.inst);
        end
    endtask

    function automatic logic [12:0] outs(input int i);
        return {ready_v[i], done_v[i], nack_v[i], sioc_v[i], siod_v[i], rdata_v[i*8 +: 8]};
    endfunction

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        logic pull = 1'b0;
        assign sda_v[gi] = ~(siod_v[gi] | pull);

        if (gi == 0) begin : g_a
            sccb_master #(.CLK_FREQ(4000), .SCCB_FREQ(100), .DEV_ADDR(7'h21),
                          .ADDR_BYTES(1), .CHECK_ACK(1'b1)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start_v[gi]), .rw(rw),
                .reg_addr(reg_addr[7:0]), .wdata(wdata), .SIOD_in(sda_v[gi]),
                .ready(ready_v[gi]), .done(done_v[gi]), .nack(nack_v[gi]),
                .rdata(rdata_v[gi*8 +: 8]), .SIOC_oe(sioc_v[gi]), .SIOD_oe(siod_v[gi]));
        end else begin : g_b
            sccb_master #(.CLK_FREQ(4000), .SCCB_FREQ(100), .DEV_ADDR(7'h21),
                          .ADDR_BYTES(2), .CHECK_ACK(1'b0)) u_dut (
                .clk(clk), .rst_n(rst_n), .start(start_v[gi]), .rw(rw),
                .reg_addr(reg_addr), .wdata(wdata), .SIOD_in(sda_v[gi]),
                .ready(ready_v[gi]), .done(done_v[gi]), .nack(nack_v[gi]),
                .rdata(rdata_v[gi*8 +: 8]), .SIOC_oe(sioc_v[gi]), .SIOD_oe(siod_v[gi]));
        end

        // Bus decoder plus slave: decodes START/STOP/bytes, acks and returns read data.
        initial begin
            int   rise_cnt, byte_no;
            logic rd_frame, pscl, psda, scl, sda, rd_now;
            logic [7:0] sr;
            rise_cnt = 0; byte_no = 0; rd_frame = 1'b0; pscl = 1'b1; psda = 1'b1; sr = 8'h00;
            forever begin
                @(negedge clk);
                scl = ~sioc_v[gi];
                sda = sda_v[gi];
                if (!rst_n) begin
                    rise_cnt = 0; byte_no = 0; rd_frame = 1'b0; pull = 1'b0;
                end else if (pscl && scl && psda && !sda) begin
                    emit(gi, T_START);
                    rise_cnt = 0; byte_no = 0; rd_frame = 1'b0;
                end else if (pscl && scl && !psda && sda) begin
                    emit(gi, T_STOP);
                    rise_cnt = 0;
                end else if (!pscl && scl) begin
                    rise_cnt++;
                    if (rise_cnt <= 8) begin
                        sr = {sr[6:0], sda};
                    end else begin
                        emit(gi, {1'b0, sda, sr});
                        if (byte_no == 0 && sr[0]) rd_frame = 1'b1;
                        byte_no++;
                        rise_cnt = 0;
                    end
                end else if (pscl && !scl) begin
                    rd_now = rd_frame && (byte_no == 1);
                    if (rd_now) pull = (rise_cnt < 8) ? ~slave_data[7 - rise_cnt] : 1'b0;
                    else        pull = (rise_cnt == 8) && ack_en;
                end
                pscl = scl;
                psda = sda;
            end
        end

        initial begin
            done_t d;
            forever begin
                @(negedge clk);
                if (rst_n && done_v[gi]) begin
                    if (dq.size() == 0) begin
                        total++;
                        $display("FAIL done[%0d]: got unexpected done pulse, expected none", gi);
                    end else begin
                        d = dq.pop_front();
                        check($sformatf("done_inst[%0d]", gi), gi, d.inst);
                        check($sformatf("done_cycle[%0d]", gi), cyc - d.t0, d.cyc);
                        check($sformatf("nack[%0d]", gi), nack_v[gi], d.nack);
                        check($sformatf("rdata[%0d]", gi), rdata_v[gi*8 +: 8], d.rdata);
                        check($sformatf("ready_with_done[%0d]", gi), ready_v[gi], 1'b1);
                    end
                end
            end
        end
    end

    task automatic exp_tok(input int inst, input logic [9:0] t);
        tok_t e;
        e.inst = inst;
        e.tok  = t;
        tq.push_back(e);
    endtask

    task automatic exp_byte(input int inst, input logic ack, input logic [7:0] b);
        exp_tok(inst, {1'b0, ack, b});
    endtask

    task automatic push_done(input int inst, input int t0, input int n, input logic nk, input logic [7:0] rd);
        done_t d;
        d.inst = inst; d.t0 = t0; d.cyc = n * Q + 1; d.nack = nk; d.rdata = rd;
        dq.push_back(d);
    endtask

    // Returns t0 such that cyc - t0 is the cycle number counted from the accepting edge.
    task automatic issue(input int inst, input logic r, input logic [15:0] a, input logic [7:0] d, output int t0);
        int n;
        n = 0;
        @(negedge clk);
        while (!ready_v[inst] && n < 3000) begin
            @(negedge clk);
            n++;
        end
        rw = r; reg_addr = a; wdata = d; start_v[inst] = 1'b1;
        @(posedge clk);
        #1;
        start_v[inst] = 1'b0;
        t0 = cyc - 1;
        check($sformatf("busy_after_start[%0d]", inst), ready_v[inst], 1'b0);
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((tq.size() != 0 || dq.size() != 0) && n < 2500) begin
            @(negedge clk);
            n++;
        end
        check(name, tq.size() + dq.size(), 0);
    endtask

    initial begin
        int t0;
        #3;
        check("reset_outputs[0]", outs(0), 13'h1000);
        check("reset_outputs[1]", outs(1), 13'h1000);
        #9 rst_n = 1'b1;

        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("idle_reset[0]", outs(0), 13'h1000);
        #1 rst_n = 1'b1;

        // Plain write, every byte acked.
        exp_tok(0, T_START); exp_byte(0, 0, 8'h42); exp_byte(0, 0, 8'h12); exp_byte(0, 0, 8'h80); exp_tok(0, T_STOP);
        issue(0, 1'b0, 16'h0012, 8'h80, t0);
        push_done(0, t0, 121, 1'b0, 8'h00);
        wait_idle("write_drained");

        // Two-phase read returning 0x76; master leaves the final slot released.
        slave_data = 8'h76;
        exp_tok(0, T_START); exp_byte(0, 0, 8'h42); exp_byte(0, 0, 8'h0A); exp_tok(0, T_STOP);
        exp_tok(0, T_START); exp_byte(0, 0, 8'h43); exp_byte(0, 1, 8'h76); exp_tok(0, T_STOP);
        issue(0, 1'b1, 16'h000A, 8'h00, t0);
        push_done(0, t0, 162, 1'b0, 8'h76);
        wait_idle("read_drained");

        // No slave ack on the device byte: abort after the first ack slot.
        ack_en = 1'b0;
        exp_tok(0, T_START); exp_byte(0, 1, 8'h42); exp_tok(0, T_STOP);
        issue(0, 1'b0, 16'h0012, 8'h80, t0);
        push_done(0, t0, 49, 1'b1, 8'h76);
        wait_idle("nack_drained");
        ack_en = 1'b1;

        // Reset in the middle of the device byte.
        exp_tok(0, T_START);
        issue(0, 1'b0, 16'h0012, 8'h80, t0);
        repeat (150) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("midbyte_reset[0]", outs(0), 13'h1000);
        #1 rst_n = 1'b1;
        wait_idle("abort_drained");

        exp_tok(0, T_START); exp_byte(0, 0, 8'h42); exp_byte(0, 0, 8'h12); exp_byte(0, 0, 8'h80); exp_tok(0, T_STOP);
        issue(0, 1'b0, 16'h0012, 8'h80, t0);
        push_done(0, t0, 121, 1'b0, 8'h00);
        wait_idle("rewrite_drained");

        // Two address bytes, with a start pulse while busy that must be ignored.
        exp_tok(1, T_START); exp_byte(1, 0, 8'h42); exp_byte(1, 0, 8'h30); exp_byte(1, 0, 8'h0A);
        exp_byte(1, 0, 8'h55); exp_tok(1, T_STOP);
        issue(1, 1'b0, 16'h300A, 8'h55, t0);
        push_done(1, t0, 157, 1'b0, 8'h00);
        repeat (300) @(negedge clk);
        start_v[1] = 1'b1;
        @(negedge clk);
        start_v[1] = 1'b0;
        wait_idle("addr16_drained");
        repeat (100) @(negedge clk);
        check("ignored_start_idle[1]", {ready_v[1], 8'(tq.size() + dq.size())}, 9'h100);

        // Acks ignored: a silent slave still gets the full write.
        ack_en = 1'b0;
        exp_tok(1, T_START); exp_byte(1, 1, 8'h42); exp_byte(1, 1, 8'h12); exp_byte(1, 1, 8'h34);
        exp_byte(1, 1, 8'hA5); exp_tok(1, T_STOP);
        issue(1, 1'b0, 16'h1234, 8'hA5, t0);
        push_done(1, t0, 157, 1'b0, 8'h00);
        wait_idle("noack_drained");
        ack_en = 1'b1;

        slave_data = 8'hC3;
        exp_tok(1, T_START); exp_byte(1, 0, 8'h42); exp_byte(1, 0, 8'h30); exp_byte(1, 0, 8'h0A); exp_tok(1, T_STOP);
        exp_tok(1, T_START); exp_byte(1, 0, 8'h43); exp_byte(1, 1, 8'hC3); exp_tok(1, T_STOP);
        issue(1, 1'b1, 16'h300A, 8'h00, t0);
        push_done(1, t0, 198, 1'b0, 8'hC3);
        wait_idle("read16_drained");

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
